// File: rtl/pdetect_lock_ctl.sv
// pdetect_lock_ctl: sequencer and lock monitor for the pdetect phase-detector stage.
// Holds pdetect in reset until armed, qualifies its phase samples against a
// symmetric window, declares lock / loss of lock, and re-arms on acquisition timeout.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   enable                run request; low forces IDLE
//   pd_ang, pd_strobe     signed phase sample and its valid from pdetect
//   lock_n, unlock_n      consecutive-sample thresholds (0 treated as 1)
//   timeout               acquisition timeout in strobes (0 = never)
//   clr_status            clears sticky flags and lost_cnt
//   pd_reset, locked      registered control / status
//   state                 0 IDLE, 1 ARM, 2 ACQUIRE, 3 LOCKED
//   timeout_flag, lost_flag, lost_cnt   sticky status for the register map
module pdetect_lock_ctl #(
  parameter int unsigned W       = 17,
  parameter int unsigned LOCK_TH = 1024,
  parameter int unsigned CW      = 8,
  parameter int unsigned TW      = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [W-1:0]  pd_ang,
  input  logic          pd_strobe,
  input  logic [CW-1:0] lock_n,
  input  logic [CW-1:0] unlock_n,
  input  logic [TW-1:0] timeout,
  input  logic          clr_status,
  output logic          pd_reset,
  output logic          locked,
  output logic [1:0]    state,
  output logic          timeout_flag,
  output logic          lost_flag,
  output logic [7:0]    lost_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_ACQ    = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  localparam logic signed [W:0] TH_POS = (W+1)'(LOCK_TH);
  localparam logic signed [W:0] TH_NEG = -TH_POS;

  state_e        state_q, state_d;
  logic [CW-1:0] good_cnt, good_d, bad_cnt, bad_d;
  logic [TW-1:0] tmo_cnt, tmo_d;
  logic          tmo_evt, lost_evt;

  // Window test on the sign-extended sample; pdetect clip codes fall outside.
  logic signed [W:0] ang_x;
  logic              in_win;
  assign ang_x  = {pd_ang[W-1], pd_ang};
  assign in_win = (ang_x >= TH_NEG) && (ang_x <= TH_POS);

  // Threshold compares done one bit wider so a saturated counter cannot wrap.
  logic [CW-1:0] lock_eff, unlock_eff;
  logic          good_hit, bad_hit, tmo_hit;
  assign lock_eff   = (lock_n   == '0) ? CW'(1) : lock_n;
  assign unlock_eff = (unlock_n == '0) ? CW'(1) : unlock_n;
  assign good_hit   = ({1'b0, good_cnt} + (CW+1)'(1)) == {1'b0, lock_eff};
  assign bad_hit    = ({1'b0, bad_cnt}  + (CW+1)'(1)) == {1'b0, unlock_eff};
  assign tmo_hit    = (timeout != '0) &&
                      (({1'b0, tmo_cnt} + (TW+1)'(1)) == {1'b0, timeout});

  logic [CW-1:0] good_sat, bad_sat;
  logic [TW-1:0] tmo_sat;
  assign good_sat = (good_cnt == '1) ? good_cnt : good_cnt + CW'(1);
  assign bad_sat  = (bad_cnt  == '1) ? bad_cnt  : bad_cnt  + CW'(1);
  assign tmo_sat  = (tmo_cnt  == '1) ? tmo_cnt  : tmo_cnt  + TW'(1);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state, counter updates and status events.
  always_comb begin
    state_d  = state_q;
    good_d   = good_cnt;
    bad_d    = bad_cnt;
    tmo_d    = tmo_cnt;
    tmo_evt  = 1'b0;
    lost_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        good_d = '0;
        bad_d  = '0;
        tmo_d  = '0;
        if (enable) state_d = ST_ARM;
      end
      ST_ARM: begin
        good_d = '0;
        bad_d  = '0;
        tmo_d  = '0;
        if (pd_strobe) state_d = ST_ACQ;
      end
      ST_ACQ: begin
        if (pd_strobe) begin
          tmo_d  = tmo_sat;
          good_d = in_win ? good_sat : '0;
          if (in_win && good_hit) begin
            state_d = ST_LOCKED;
            bad_d   = '0;
          end else if (tmo_hit) begin
            state_d = ST_ARM;
            tmo_evt = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (pd_strobe) begin
          bad_d = in_win ? '0 : bad_sat;
          if (!in_win && bad_hit) begin
            state_d  = ST_ACQ;
            lost_evt = 1'b1;
            good_d   = '0;
            tmo_d    = '0;
            bad_d    = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Dropping enable overrides every other transition.
    if (!enable) begin
      state_d  = ST_IDLE;
      tmo_evt  = 1'b0;
      lost_evt = 1'b0;
    end
  end

  // Counters, registered outputs and sticky status (set beats clear).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      good_cnt     <= '0;
      bad_cnt      <= '0;
      tmo_cnt      <= '0;
      pd_reset     <= 1'b1;
      locked       <= 1'b0;
      timeout_flag <= 1'b0;
      lost_flag    <= 1'b0;
      lost_cnt     <= '0;
    end else begin
      good_cnt     <= good_d;
      bad_cnt      <= bad_d;
      tmo_cnt      <= tmo_d;
      pd_reset     <= (state_d == ST_IDLE) || (state_d == ST_ARM);
      locked       <= (state_d == ST_LOCKED);
      timeout_flag <= tmo_evt  | (timeout_flag & ~clr_status);
      lost_flag    <= lost_evt | (lost_flag & ~clr_status);
      if (lost_evt) begin
        if (clr_status)            lost_cnt <= 8'd1;
        else if (lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
      end else if (clr_status) begin
        lost_cnt <= '0;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pdetect_lock_ctl.sv
module tb_pdetect_lock_ctl;
  localparam int unsigned W  = 17;
  localparam int unsigned CW = 8;
  localparam int unsigned TW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [W-1:0]  pd_ang;
  logic          pd_strobe;
  logic [CW-1:0] lock_n;
  logic [CW-1:0] unlock_n;
  logic [TW-1:0] timeout;
  logic          clr_status;
  logic          pd_reset;
  logic          locked;
  logic [1:0]    state;
  logic          timeout_flag;
  logic          lost_flag;
  logic [7:0]    lost_cnt;

  int checks   = 0;
  int failures = 0;

  pdetect_lock_ctl #(.W(W), .LOCK_TH(1024), .CW(CW), .TW(TW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pd_ang(pd_ang),
    .pd_strobe(pd_strobe), .lock_n(lock_n), .unlock_n(unlock_n),
    .timeout(timeout), .clr_status(clr_status), .pd_reset(pd_reset),
    .locked(locked), .state(state), .timeout_flag(timeout_flag),
    .lost_flag(lost_flag), .lost_cnt(lost_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe carrying sample a; returns 1 ns after the capturing edge.
  task automatic strobe(input logic [W-1:0] a);
    pd_ang    = a;
    pd_strobe = 1'b1;
    tick();
    pd_strobe = 1'b0;
  endtask

  localparam logic [W-1:0] CLIP_P = 17'h0FFFF;
  localparam logic [W-1:0] CLIP_N = 17'h10000;

  logic [W-1:0] win_v [10];
  logic [W-1:0] loss_v [4];

  initial begin
    win_v[0] = 17'(1024);  win_v[1] = 17'(-1025); win_v[2] = 17'(-1024);
    win_v[3] = CLIP_N;     win_v[4] = 17'(1024);  win_v[5] = 17'(-1024);
    win_v[6] = 17'(1025);  win_v[7] = 17'(1024);  win_v[8] = 17'(-1024);
    win_v[9] = 17'(1024);
    loss_v[0] = CLIP_P; loss_v[1] = 17'(0); loss_v[2] = 17'(-1025); loss_v[3] = CLIP_P;

    reset_n = 1'b0; enable = 1'b0; pd_ang = '0; pd_strobe = 1'b0;
    lock_n = 8'd4; unlock_n = 8'd2; timeout = '0; clr_status = 1'b0;
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pd_reset", 32'(pd_reset), 32'd1);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_tflag", 32'(timeout_flag), 32'd0);
    chk("rst_lflag", 32'(lost_flag), 32'd0);
    chk("rst_lost_cnt", 32'(lost_cnt), 32'd0);
    tick();
    reset_n = 1'b1;

    // Idle with strobes: nothing moves while enable is low.
    for (int i = 0; i < 3; i++) begin
      strobe('0);
      chk("idle_state", 32'(state), 32'd0);
      chk("idle_pd_reset", 32'(pd_reset), 32'd1);
      chk("idle_locked", 32'(locked), 32'd0);
    end

    // Clean lock: one arm strobe then four in-window strobes.
    enable = 1'b1;
    tick();
    chk("arm_state", 32'(state), 32'd1);
    chk("arm_pd_reset", 32'(pd_reset), 32'd1);
    strobe(17'd100);
    chk("acq_state", 32'(state), 32'd2);
    chk("acq_pd_reset", 32'(pd_reset), 32'd0);
    repeat (3) tick();
    for (int i = 1; i <= 4; i++) begin
      strobe(17'd100);
      chk("clean_locked", 32'(locked), 32'(i == 4));
      repeat (3) tick();
    end
    chk("clean_state", 32'(state), 32'd3);
    chk("clean_pd_reset", 32'(pd_reset), 32'd0);

    // Window edges with lock_n=3.
    enable = 1'b0;
    tick();
    chk("dis_state", 32'(state), 32'd0);
    enable = 1'b1;
    lock_n = 8'd3;
    tick();
    strobe('0);
    chk("win_arm_done", 32'(state), 32'd2);
    for (int i = 0; i < 10; i++) begin
      strobe(win_v[i]);
      chk($sformatf("win_state_%0d", i), 32'(state), (i == 9) ? 32'd3 : 32'd2);
    end
    chk("win_locked", 32'(locked), 32'd1);

    // Loss of lock with unlock_n=2: bad, good, bad, bad.
    unlock_n = 8'd2;
    for (int i = 0; i < 4; i++) begin
      strobe(loss_v[i]);
      chk($sformatf("loss_state_%0d", i), 32'(state), (i == 3) ? 32'd2 : 32'd3);
    end
    chk("loss_locked", 32'(locked), 32'd0);
    chk("loss_lflag", 32'(lost_flag), 32'd1);
    chk("loss_cnt1", 32'(lost_cnt), 32'd1);

    // 299 more losses: lost_cnt saturates.
    lock_n = 8'd1;
    unlock_n = 8'd0;
    for (int i = 0; i < 299; i++) begin
      strobe('0);
      strobe(CLIP_P);
    end
    chk("sat_state", 32'(state), 32'd2);
    chk("sat_lost_cnt", 32'(lost_cnt), 32'd255);

    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("clr_lflag", 32'(lost_flag), 32'd0);
    chk("clr_lost_cnt", 32'(lost_cnt), 32'd0);

    // Acquisition timeout on clipped samples.
    timeout = 16'd10;
    for (int i = 1; i <= 10; i++) begin
      strobe(CLIP_P);
      chk($sformatf("tmo1_state_%0d", i), 32'(state), (i == 10) ? 32'd1 : 32'd2);
    end
    chk("tmo1_flag", 32'(timeout_flag), 32'd1);
    repeat (5) tick();
    chk("tmo1_pd_reset_hold", 32'(pd_reset), 32'd1);
    chk("tmo1_state_hold", 32'(state), 32'd1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("tmo_clr_flag", 32'(timeout_flag), 32'd0);

    // Second round (11 strobes), clr_status coincident with the timeout.
    strobe(CLIP_P);
    chk("tmo2_arm", 32'(state), 32'd2);
    for (int i = 1; i <= 9; i++) strobe(CLIP_P);
    chk("tmo2_state_9", 32'(state), 32'd2);
    clr_status = 1'b1;
    strobe(CLIP_P);
    clr_status = 1'b0;
    chk("tmo2_state_10", 32'(state), 32'd1);
    chk("tmo2_flag_set_wins", 32'(timeout_flag), 32'd1);

    // enable dropped during ACQUIRE.
    strobe(CLIP_P);
    chk("ovr_acq", 32'(state), 32'd2);
    enable = 1'b0;
    tick();
    chk("ovr_state", 32'(state), 32'd0);
    chk("ovr_pd_reset", 32'(pd_reset), 32'd1);
    chk("ovr_tflag_kept", 32'(timeout_flag), 32'd1);

    // Async reset between edges while LOCKED.
    enable = 1'b1;
    tick();
    strobe('0);
    strobe('0);
    chk("ar_locked", 32'(locked), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("ar_state", 32'(state), 32'd0);
    chk("ar_locked0", 32'(locked), 32'd0);
    chk("ar_pd_reset", 32'(pd_reset), 32'd1);
    chk("ar_tflag", 32'(timeout_flag), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
